// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: register-file write-port scheduler for WB and aux results.
// Optional aux starvation guard enabled by defining WB_ARB_STARVE_EN.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic        pipe_double,
  input  logic [4:0]  pipe_rd,
  input  logic [63:0] pipe_data,
  output logic        pipe_stall,
  input  logic        aux_valid,
  input  logic        aux_double,
  input  logic [4:0]  aux_rd,
  input  logic [63:0] aux_data,
  output logic        aux_ready,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        rf_src,
  output logic        busy
);

  typedef enum logic {IDLE, DBL2} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic        force_aux;
  logic        grant_pipe, grant_aux;
  logic        sel_double;
  logic [4:0]  sel_rd, sel_base;
  logic [63:0] sel_data;
  logic [4:0]  hold_addr;
  logic [31:0] hold_data;

`ifdef WB_ARB_STARVE_EN
  logic [3:0] starve_cnt;

  // count refused aux cycles, saturating; clear on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (aux_valid && aux_ready) begin
      starve_cnt <= 4'd0;
    end else if (aux_valid && starve_cnt != LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force_aux = aux_valid && (starve_cnt == LIM);
`else
  logic unused_lim;
  assign unused_lim = ^LIM;
  assign force_aux  = 1'b0;
`endif

  // grant selection, handshakes and next state
  always_comb begin
    grant_pipe = 1'b0;
    grant_aux  = 1'b0;
    pipe_stall = 1'b0;
    aux_ready  = 1'b0;
    state_nxt  = state;
    unique case (state)
      IDLE: begin
        if (force_aux) begin
          grant_aux  = 1'b1;
          aux_ready  = 1'b1;
          pipe_stall = pipe_valid;
        end else if (pipe_valid) begin
          grant_pipe = 1'b1;
        end else if (aux_valid) begin
          grant_aux = 1'b1;
          aux_ready = 1'b1;
        end
        if ((grant_pipe && pipe_double) ||
            (grant_aux && aux_double))
          state_nxt = DBL2;
      end
      DBL2: begin
        pipe_stall = pipe_valid;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_double = grant_aux ? aux_double : pipe_double;
  assign sel_rd     = grant_aux ? aux_rd     : pipe_rd;
  assign sel_data   = grant_aux ? aux_data   : pipe_data;
  assign sel_base   = sel_rd & 5'b11110;

  // state register, registered write port and held second word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rf_we     <= 1'b0;
      rf_addr   <= 5'd0;
      rf_data   <= 32'd0;
      rf_src    <= 1'b0;
      hold_addr <= 5'd0;
      hold_data <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == DBL2) begin
        rf_we   <= (hold_addr != 5'd0);
        rf_addr <= hold_addr;
        rf_data <= hold_data;
      end else if (grant_pipe || grant_aux) begin
        rf_src <= grant_aux;
        if (sel_double) begin
          rf_we     <= (sel_base != 5'd0);
          rf_addr   <= sel_base;
          rf_data   <= sel_data[63:32];
          hold_addr <= sel_base | 5'd1;
          hold_data <= sel_data[31:0];
        end else begin
          rf_we   <= (sel_rd != 5'd0);
          rf_addr <= sel_rd;
          rf_data <= sel_data[31:0];
        end
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

  assign busy = (state == DBL2);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector table plus multi-cycle sequences.
// Covers the default build and WB_ARB_STARVE_EN when defined.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_double;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_data;
  logic        pipe_stall;
  logic        aux_valid, aux_double;
  logic [4:0]  aux_rd;
  logic [63:0] aux_data;
  logic        aux_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        rf_src;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_double(pipe_double),
    .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .aux_valid(aux_valid), .aux_double(aux_double),
    .aux_rd(aux_rd), .aux_data(aux_data),
    .aux_ready(aux_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .rf_src(rf_src), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv, pd;
    logic [4:0]  prd;
    logic [63:0] pdat;
    logic        av, ad;
    logic [4:0]  ard;
    logic [63:0] adat;
    logic        st, rdy;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] dat;
    logic        src, bsy;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic pd, input logic [4:0] prd,
                       input logic [63:0] pdat, input logic av, input logic ad,
                       input logic [4:0] ard, input logic [63:0] adat);
    pipe_valid = pv; pipe_double = pd; pipe_rd = prd; pipe_data = pdat;
    aux_valid = av; aux_double = ad; aux_rd = ard; aux_data = adat;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [39:0] regs();
    return {rf_we, rf_addr, rf_data, rf_src, busy};
  endfunction

  initial begin
    vt[0]  = '{1,0,5'd3,64'hDEADBEEF,0,0,5'd0,64'd0,
               0,0, 1,5'd3,32'hDEADBEEF,0,0};
    vt[1]  = '{1,1,5'd7,64'hAAAA0000_BBBB1111,0,0,5'd0,64'd0,
               0,0, 1,5'd6,32'hAAAA0000,0,1};
    vt[2]  = '{1,0,5'd9,64'h12345678,0,0,5'd0,64'd0,
               1,0, 1,5'd7,32'hBBBB1111,0,0};
    vt[3]  = '{1,0,5'd9,64'h12345678,0,0,5'd0,64'd0,
               0,0, 1,5'd9,32'h12345678,0,0};
    vt[4]  = '{0,0,5'd0,64'd0,0,0,5'd0,64'd0,
               0,0, 0,5'd9,32'h12345678,0,0};
    vt[5]  = '{1,1,5'd0,64'h00000001_00000002,0,0,5'd0,64'd0,
               0,0, 0,5'd0,32'h00000001,0,1};
    vt[6]  = '{0,0,5'd0,64'd0,0,0,5'd0,64'd0,
               0,0, 1,5'd1,32'h00000002,0,0};
    vt[7]  = '{1,0,5'd0,64'h55,0,0,5'd0,64'd0,
               0,0, 0,5'd0,32'h00000055,0,0};
    vt[8]  = '{0,0,5'd0,64'd0,1,0,5'd10,64'hCAFE0001,
               0,1, 1,5'd10,32'hCAFE0001,1,0};
    vt[9]  = '{1,0,5'd11,64'h0B,1,0,5'd12,64'h0C,
               0,0, 1,5'd11,32'h0000000B,0,0};
    vt[10] = '{0,0,5'd0,64'd0,1,0,5'd12,64'h0C,
               0,1, 1,5'd12,32'h0000000C,1,0};
    vt[11] = '{0,0,5'd0,64'd0,1,1,5'd13,64'h13131313_31313131,
               0,1, 1,5'd12,32'h13131313,1,1};
    vt[12] = '{1,0,5'd2,64'h22,0,0,5'd0,64'd0,
               1,0, 1,5'd13,32'h31313131,1,0};
    vt[13] = '{1,0,5'd2,64'h22,0,0,5'd0,64'd0,
               0,0, 1,5'd2,32'h00000022,0,0};

    do_reset();
    chk("reset_regs", {24'd0, regs()}, 64'd0);

    // table: one vector per cycle, comb handshakes then registered port
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].pv, vt[i].pd, vt[i].prd, vt[i].pdat,
            vt[i].av, vt[i].ad, vt[i].ard, vt[i].adat);
      #1;
      chk($sformatf("vec%0d_hs", i), {62'd0, pipe_stall, aux_ready},
          {62'd0, vt[i].st, vt[i].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rf", i), {24'd0, regs()},
          {24'd0, vt[i].we, vt[i].addr, vt[i].dat, vt[i].src, vt[i].bsy});
    end

    // reset during second word of a double
    do_reset();
    drive(1, 1, 5'd4, 64'h11111111_22222222, 0, 0, 5'd0, 64'd0);
    @(posedge clk);
    #1;
    idle_in();
    chk("rst_first_word", {24'd0, regs()},
        {24'd0, 1'b1, 5'd4, 32'h11111111, 1'b0, 1'b1});
    #2 reset = 1'b1;
    #1;
    chk("rst_async", {24'd0, regs()}, 64'd0);
    @(posedge clk);
    #1;
    chk("rst_no_r5", {24'd0, regs()}, 64'd0);
    reset = 1'b0;

    // continuous pipe traffic with a waiting aux request
    do_reset();
    drive(1, 0, 5'd20, 64'h20, 1, 0, 5'd21, 64'h21);
`ifdef WB_ARB_STARVE_EN
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("starve_c%0d", c), {62'd0, pipe_stall, aux_ready},
          {62'd0, (c == 5), (c == 5)});
      @(posedge clk);
      #1;
    end
    chk("starve_grant", {24'd0, regs()},
        {24'd0, 1'b1, 5'd21, 32'h21, 1'b1, 1'b0});
`else
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk($sformatf("nostarve_c%0d", c), {62'd0, pipe_stall, aux_ready},
          {62'd0, 1'b0, 1'b0});
      @(posedge clk);
      #1;
    end
    chk("pipe_first", {24'd0, regs()},
        {24'd0, 1'b1, 5'd20, 32'h20, 1'b0, 1'b0});
    pipe_valid = 1'b0;
    #1;
    chk("aux_on_drop", {62'd0, pipe_stall, aux_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("aux_write", {24'd0, regs()},
        {24'd0, 1'b1, 5'd21, 32'h21, 1'b1, 1'b0});
`endif

    idle_in();
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Scheduler for the integer register-file write port, placed between the WB stage, the long-latency auxiliary unit (mul/div result return), and the single 32-bit register-file write port. Each cycle it grants the port to one requester, splits double-word writes (LDD, regDouble_en) into two sequential single-register writes, suppresses writes to %g0, and stalls the pipeline while the port is occupied. All register-file write outputs are registered.

## Interface
- STARVE_LIMIT, default 4: the number of consecutive cycles the aux unit may be refused before it is force-granted (only with `WB_ARB_STARVE_EN`). Range 1..15.
- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-high.
- pipe_valid  in  1  WB stage has a register write (WB_reg_en or WB_regDouble_en).
- pipe_double  in  1  double-word write (WB_regDouble_en).
- pipe_rd  in  5  destination register (WB_regD_out).
- pipe_data  in  64  write data (WB_data_out); single writes use [31:0].
- pipe_stall  out  1  pipe request not accepted this cycle; WB holds its inputs.
- aux_valid  in  1  aux unit has a result.
- aux_double  in  1  double-word aux result.
- aux_rd  in  5  aux destination register.
- aux_data  in  64  aux result data.
- aux_ready  out  1  aux request accepted this cycle.
- rf_we  out  1  register-file write enable.
- rf_addr  out  5  register-file write address.
- rf_data  out  32  register-file write data.
- rf_src  out  1  source of the current write: 0 = pipe, 1 = aux.
- busy  out  1  state is DBL2.

## Operation
- FSM states:
  - IDLE: a grant can be made.
  - DBL2: the second word of a double is being emitted.
- Accept conditions:
  - Pipe request: pipe_valid & !pipe_stall.
  - Aux request: aux_valid & aux_ready.
- Grant in IDLE, in priority order:
  1. force_aux (aux_valid & starve_cnt == STARVE_LIMIT): grant aux; pipe_stall = pipe_valid.
  2. pipe_valid: grant pipe; aux_ready = 0.
  3. aux_valid: grant aux.
- In DBL2: pipe_stall = pipe_valid, aux_ready = 0, and the FSM returns to IDLE next cycle.
- Single grant: next cycle rf_addr = rd and rf_data = data[31:0].
- Double grant:
  - Address base is rd & 5'b11110 (odd rd LSB is masked).
  - Next cycle: even register gets data[63:32].
  - Following cycle (DBL2): base|1 gets data[31:0].
  - The second word is held in an internal register, so requester inputs may change after acceptance.
- rf_we = 1 on each emitted word unless its address is 0 (the %g0 write is suppressed, and the slot is still consumed).
- With nothing accepted: rf_we = 0, and rf_addr/rf_data/rf_src hold their last values.
- starve_cnt (4-bit):
  - Increments, saturating at STARVE_LIMIT, on each cycle with aux_valid & !aux_ready.
  - Cleared on aux acceptance.

## Timing
- Reset values: state IDLE, starve_cnt 0, rf_we 0, rf_addr 0, rf_data 0, rf_src 0, busy 0.
- Latency:
  - Acceptance in cycle N → write visible in N+1.
  - Second word of a double in N+2.
  - Back-to-back singles sustain one write per cycle.
- A double occupies the port for two cycles; the next grant is possible in N+2, with its write in N+3.
- Simultaneous pipe and aux requests: pipe wins unless force_aux holds.
- Reset asserted mid-double: the second word is discarded and outputs return to reset values immediately.
- pipe_stall and aux_ready are combinational from state, starve_cnt and the valids. No combinational path exists from the data inputs.

## Configuration
- `WB_ARB_STARVE_EN` defined:
  - starve_cnt and force_aux are implemented as described.
  - Aux is guaranteed a grant within STARVE_LIMIT+2 cycles of asserting aux_valid.
- Undefined:
  - No counter; force_aux is constant 0.
  - Pipe has strict priority, and aux is granted only in IDLE cycles with !pipe_valid.

## Test plan
- **Reset:** assert reset mid-double (LDD rd=4 data=64'h11111111_22222222, reset in N+1) → in N+2 rf_we=0, busy=0, no write to r5.
- **Single write:** pipe single rd=3 data=32'hDEADBEEF at N → N+1: rf_we=1, rf_addr=3, rf_data=DEADBEEF, rf_src=0.
- **Double write:** pipe double rd=7 data=64'hAAAA0000_BBBB1111 → N+1: r6=AAAA0000; N+2: r7=BBBB1111; pipe_stall=1 in N+1.
- **%g0 suppression:** pipe double rd=0 data=64'h1_2 → N+1: rf_we=0; N+2: rf_we=1, addr=1, data=2. A pipe single rd=0 produces no write.
- **Simultaneous requests:** pipe and aux valid in the same cycle → pipe written first, aux_ready=0 that cycle, aux accepted the first cycle pipe_valid drops.
- **Starvation guard (STARVE_EN, LIMIT=4):** continuous pipe_valid plus aux_valid → aux_ready=1 on the 5th cycle with pipe_stall=1 and rf_src=1 the next cycle. Without the macro, aux_ready stays 0 throughout.
